// File: rtl/alu_sched_if.sv
// ---------------------------------------------------------------------------
// alu_sched_if
//   Bundles the requester side and the ALU side of the alu_sched block.
//   Slot i of every packed requester bus sits at [W*(i+1)-1 : W*i].
//
//   Requester side : req_op_i, req_key_i, req_a_i, req_b_i  (into scheduler)
//                    res_o, res_key_o, res_valid_o, err_o   (out of scheduler)
//   ALU side       : alu_op_o, alu_key_o, alu_a_o, alu_b_o  (out of scheduler)
//                    alu_key_i, alu_res_i                   (into scheduler)
//   Status         : busy_o
//
//   slave  : the scheduler's view.
//   master : the environment's view (requesters plus ALU).
// ---------------------------------------------------------------------------
interface alu_sched_if #(
   parameter int NREQ = 4,
   parameter int OPW  = 4,
   parameter int KW   = 8,
   parameter int DW   = 32
);
   logic [NREQ*OPW-1:0] req_op_i;
   logic [NREQ*KW-1:0]  req_key_i;
   logic [NREQ*DW-1:0]  req_a_i;
   logic [NREQ*DW-1:0]  req_b_i;

   logic [OPW-1:0]      alu_op_o;
   logic [KW-1:0]       alu_key_o;
   logic [DW-1:0]       alu_a_o;
   logic [DW-1:0]       alu_b_o;
   logic [KW-1:0]       alu_key_i;
   logic [DW-1:0]       alu_res_i;

   logic [DW-1:0]       res_o;
   logic [KW-1:0]       res_key_o;
   logic [NREQ-1:0]     res_valid_o;
   logic [NREQ-1:0]     err_o;
   logic                busy_o;

   modport slave (
      input  req_op_i, req_key_i, req_a_i, req_b_i, alu_key_i, alu_res_i,
      output alu_op_o, alu_key_o, alu_a_o, alu_b_o,
             res_o, res_key_o, res_valid_o, err_o, busy_o
   );

   modport master (
      output req_op_i, req_key_i, req_a_i, req_b_i, alu_key_i, alu_res_i,
      input  alu_op_o, alu_key_o, alu_a_o, alu_b_o,
             res_o, res_key_o, res_valid_o, err_o, busy_o
   );
endinterface

// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------
// alu_sched
//   Shares one tagged ALU between NREQ requesters. A requester raises a
//   request by changing its key; the scheduler issues one operation at a time
//   (round-robin), tags it with a non-zero sequence number, and waits for the
//   ALU to echo that tag. The result is returned with the requester's key and
//   a one-cycle strobe; a missing echo aborts after TIMEOUT cycles with a
//   one-cycle error strobe.
//
//   Ports:
//     clk  : single clock, rising edge
//     rst  : asynchronous, active-low reset
//     bus  : alu_sched_if.slave (requester buses, ALU buses, results, busy)
// ---------------------------------------------------------------------------
module alu_sched #(
   parameter int NREQ    = 4,
   parameter int OPW     = 4,
   parameter int KW      = 8,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input logic        clk,
   input logic        rst,
   alu_sched_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state, state_nxt;
   logic [KW-1:0]   acc_key [NREQ];   // last key accepted per slot
   logic [KW-1:0]   seq;              // next tag to issue, never 0
   logic [KW-1:0]   saved_key;        // requester key of the in-flight op
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   owner_inc;
   logic [CW-1:0]   count;

   logic [NREQ-1:0] pending;
   logic            any_pending;
   logic [PW-1:0]   grant_idx;
   logic [OPW-1:0]  g_op;
   logic [KW-1:0]   g_key;
   logic [DW-1:0]   g_a;
   logic [DW-1:0]   g_b;
   logic            match;
   logic            expired;
   logic            do_grant;
   logic            do_done;
   logic            do_abort;

   // Pending detection and round-robin pick, starting the scan at rr_ptr.
   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      int            idx;
      logic [PW-1:0] sel;
      pending     = '0;
      any_pending = 1'b0;
      grant_idx   = '0;
      g_op        = '0;
      g_key       = '0;
      g_a         = '0;
      g_b         = '0;
      for (int i = 0; i < NREQ; i++) begin
         pending[i] = (bus.req_key_i[KW*i +: KW] != acc_key[i]);
      end
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         sel = PW'(idx);
         if (!any_pending && pending[sel]) begin
            any_pending = 1'b1;
            grant_idx   = sel;
            g_op        = bus.req_op_i[OPW*idx +: OPW];
            g_key       = bus.req_key_i[KW*idx +: KW];
            g_a         = bus.req_a_i[DW*idx +: DW];
            g_b         = bus.req_b_i[DW*idx +: DW];
         end
      end
   end

   assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
   assign match     = (bus.alu_key_i == bus.alu_key_o);
   assign expired   = (count == CW'(TIMEOUT - 1));

   // Next-state logic. A match on the timeout cycle wins over the abort.
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_done   = 1'b0;
      do_abort  = 1'b0;
      case (state)
         IDLE: begin
            if (any_pending) begin
               do_grant  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (match) begin
               do_done   = 1'b1;
               state_nxt = IDLE;
            end else if (expired) begin
               do_abort  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the per-slot key array is reset explicitly; after reset every
         // slot whose key differs from 0 must read as pending.
         for (int i = 0; i < NREQ; i++) acc_key[i] <= '0;
         seq             <= KW'(1);
         saved_key       <= '0;
         rr_ptr          <= '0;
         owner           <= '0;
         count           <= '0;
         bus.alu_op_o    <= '0;
         bus.alu_key_o   <= '0;
         bus.alu_a_o     <= '0;
         bus.alu_b_o     <= '0;
         bus.res_o       <= '0;
         bus.res_key_o   <= '0;
         bus.res_valid_o <= '0;
         bus.err_o       <= '0;
         bus.busy_o      <= 1'b0;
      end else begin
         // Strobes are one cycle wide unless re-set below.
         bus.res_valid_o <= '0;
         bus.err_o       <= '0;

         if (do_grant) begin
            acc_key[grant_idx] <= g_key;
            saved_key          <= g_key;
            owner              <= grant_idx;
            bus.alu_op_o       <= g_op;
            bus.alu_a_o        <= g_a;
            bus.alu_b_o        <= g_b;
            bus.alu_key_o      <= seq;
            // Tag 0 is skipped so a cleared echo bus can never match.
            seq                <= (seq == {KW{1'b1}}) ? KW'(1) : seq + KW'(1);
            count              <= '0;
            bus.busy_o         <= 1'b1;
         end

         if (do_done) begin
            bus.res_o       <= bus.alu_res_i;
            bus.res_key_o   <= saved_key;
            bus.res_valid_o <= NREQ'(1) << owner;
            rr_ptr          <= owner_inc;
            bus.busy_o      <= 1'b0;
         end else if (do_abort) begin
            bus.err_o       <= NREQ'(1) << owner;
            rr_ptr          <= owner_inc;
            bus.busy_o      <= 1'b0;
         end else if (state == WAIT) begin
            count <= count + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_alu_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_sched
//   Self-checking bench for alu_sched. The bench plays both the requesters
//   and the ALU. A small reference model (key arrays, round-robin pointer,
//   expected tag) predicts grant order, tags, results and strobes.
// ---------------------------------------------------------------------------
module tb_alu_sched;
   localparam int NREQ    = 4;
   localparam int OPW     = 4;
   localparam int KW      = 8;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   alu_sched_if #(.NREQ(NREQ), .OPW(OPW), .KW(KW), .DW(DW)) bus ();

   alu_sched #(
      .NREQ(NREQ), .OPW(OPW), .KW(KW), .DW(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model
   int          m_key [NREQ];
   int          m_acc [NREQ];
   int          m_op  [NREQ];
   logic [31:0] m_a   [NREQ];
   logic [31:0] m_b   [NREQ];
   int          m_rr;
   int          exp_tag;
   logic [31:0] last_res;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_key_i[KW*i +: KW]  = KW'(m_key[i]);
         bus.req_op_i[OPW*i +: OPW] = OPW'(m_op[i]);
         bus.req_a_i[DW*i +: DW]    = m_a[i];
         bus.req_b_i[DW*i +: DW]    = m_b[i];
      end
   endtask

   task automatic set_req(input int s, input int key, input int op,
                          input logic [31:0] a, input logic [31:0] b);
      m_key[s] = key;
      m_op[s]  = op;
      m_a[s]   = a;
      m_b[s]   = b;
      apply();
   endtask

   // First slot with an unaccepted key, scanning from the round-robin pointer.
   function automatic int pick();
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_rr + k) % NREQ;
         if (m_key[idx] != m_acc[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic check_issue(input int g);
      check("issue_busy", bus.busy_o, 1);
      check("issue_tag",  bus.alu_key_o, exp_tag);
      check("issue_op",   bus.alu_op_o, m_op[g]);
      check("issue_a",    bus.alu_a_o, m_a[g]);
      check("issue_b",    bus.alu_b_o, m_b[g]);
   endtask

   // Called with the grant already visible. The ALU echoes after lat cycles.
   // Optionally changes one slot's key right after the grant.
   task automatic serve(input int lat, input int chg_slot, input int chg_key);
      int          g;
      int          skey;
      logic [31:0] r;
      g = pick();
      if (g < 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL serve_no_pending observed=none expected=pending_slot");
         return;
      end
      check_issue(g);
      skey     = m_key[g];
      m_acc[g] = m_key[g];
      for (int k = 0; k < lat; k++) begin
         if (k == 0 && chg_slot >= 0) begin
            m_key[chg_slot] = chg_key;
            apply();
         end
         tick();
         check("wait_busy",       bus.busy_o, 1);
         check("wait_tag_stable", bus.alu_key_o, exp_tag);
         check("wait_no_strobe",  {bus.res_valid_o, bus.err_o}, 0);
      end
      r             = $urandom;
      bus.alu_key_i = KW'(exp_tag);
      bus.alu_res_i = r;
      tick();
      check("done_valid",    bus.res_valid_o, 1 << g);
      check("done_err",      bus.err_o, 0);
      check("done_res",      bus.res_o, r);
      check("done_key",      bus.res_key_o, skey);
      check("done_busy",     bus.busy_o, 0);
      check("done_hold_tag", bus.alu_key_o, exp_tag);
      bus.alu_key_i = '0;
      bus.alu_res_i = $urandom;
      last_res      = r;
      m_rr          = (g + 1) % NREQ;
      exp_tag       = exp_tag % 255 + 1;
      tick();
      check("valid_one_cycle", bus.res_valid_o, 0);
   endtask

   // Called with the grant already visible; the ALU never answers.
   task automatic serve_timeout();
      int g;
      int stale;
      g = pick();
      if (g < 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL timeout_no_pending observed=none expected=pending_slot");
         return;
      end
      check_issue(g);
      m_acc[g] = m_key[g];
      for (int k = 1; k < TIMEOUT; k++) begin
         tick();
         check("to_wait_err",  bus.err_o, 0);
         check("to_wait_busy", bus.busy_o, 1);
      end
      tick();
      check("to_err",       bus.err_o, 1 << g);
      check("to_no_valid",  bus.res_valid_o, 0);
      check("to_busy",      bus.busy_o, 0);
      check("to_res_hold",  bus.res_o, last_res);
      check("to_tag_hold",  bus.alu_key_o, exp_tag);
      stale   = exp_tag;
      m_rr    = (g + 1) % NREQ;
      exp_tag = exp_tag % 255 + 1;
      // Late echo of the aborted tag arrives while idle and stays on the bus.
      bus.alu_key_i = KW'(stale);
      tick();
      check("to_err_one_cycle", bus.err_o, 0);
      check("late_echo_valid",  bus.res_valid_o, 0);
      tick();
      check("late_echo_idle",   {bus.res_valid_o, bus.err_o, bus.busy_o}, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  bus.busy_o, 0);
      check({tag, "_aop"},   bus.alu_op_o, 0);
      check({tag, "_akey"},  bus.alu_key_o, 0);
      check({tag, "_aa"},    bus.alu_a_o, 0);
      check({tag, "_ab"},    bus.alu_b_o, 0);
      check({tag, "_res"},   bus.res_o, 0);
      check({tag, "_rkey"},  bus.res_key_o, 0);
      check({tag, "_valid"}, bus.res_valid_o, 0);
      check({tag, "_err"},   bus.err_o, 0);
   endtask

   // Asserts reset between clock edges and releases it mid-cycle.
   task automatic do_reset(input int keep_slot, input int keep_key);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("rst_async");
      for (int i = 0; i < NREQ; i++) begin
         m_key[i] = 0;
         m_acc[i] = 0;
      end
      if (keep_slot >= 0) m_key[keep_slot] = keep_key;
      apply();
      bus.alu_key_i = '0;
      m_rr     = 0;
      exp_tag  = 1;
      last_res = '0;
      tick();
      check("rst_held_strobes", {bus.res_valid_o, bus.err_o, bus.busy_o}, 0);
      #3;
      rst = 1'b1;
      #1;
      check("rst_release_idle", {bus.res_valid_o, bus.err_o, bus.busy_o}, 0);
   endtask

   initial begin
      int n_issued;
      int mask;
      int npend;

      for (int i = 0; i < NREQ; i++) begin
         m_key[i] = 0;
         m_acc[i] = 0;
         m_op[i]  = 0;
         m_a[i]   = '0;
         m_b[i]   = '0;
      end
      m_rr     = 0;
      exp_tag  = 1;
      last_res = '0;
      apply();
      bus.alu_key_i = '0;
      bus.alu_res_i = '0;

      // Power-on reset
      #1;
      rst = 1'b0;
      #1;
      check_all_zero("por");
      tick();
      tick();
      #3;
      rst = 1'b1;
      tick();
      check_all_zero("por_idle");

      // Single request on slot 2, echo after 3 cycles
      set_req(2, 8'h05, 3, 32'd7, 32'd9);
      tick();
      serve(3, -1, 0);
      check("single_idle_busy", bus.busy_o, 0);
      tick();
      check("single_hold_op",  bus.alu_op_o, 3);
      check("single_hold_tag", bus.alu_key_o, 1);
      check("single_hold_a",   bus.alu_a_o, 7);

      // Fairness: all slots at once, then slots 0 and 3
      do_reset(-1, 0);
      tick();
      for (int i = 0; i < NREQ; i++) begin
         m_key[i] = 8'h20 + i;
         m_op[i]  = 8 + i;
         m_a[i]   = $urandom;
         m_b[i]   = $urandom;
      end
      apply();
      tick();
      for (int i = 0; i < NREQ; i++) serve($urandom_range(0, 6), -1, 0);
      set_req(0, 8'h30, 1, $urandom, $urandom);
      set_req(3, 8'h33, 2, $urandom, $urandom);
      tick();
      serve(1, -1, 0);
      serve(2, -1, 0);
      check("fair_rr_after_slot3", m_rr, 0);
      check("fair_next_tag", exp_tag, 7);

      // Timeout, then a new issue with the stale tag still on the echo bus
      set_req(1, 8'h31, 5, $urandom, $urandom);
      tick();
      serve_timeout();
      set_req(2, 8'h32, 6, $urandom, $urandom);
      tick();
      serve(2, -1, 0);

      // Echo on the very cycle the timeout would fire: match wins
      set_req(3, 8'h43, 7, $urandom, $urandom);
      tick();
      serve(TIMEOUT - 1, -1, 0);

      // Key change on the in-flight slot becomes a second request
      set_req(1, 8'h10, 4, $urandom, $urandom);
      tick();
      serve(3, 1, 8'h11);
      serve(2, -1, 0);
      check("inflight_idle", bus.busy_o, 0);

      // Collapsing key changes before grant: only the last value is issued
      m_key[0] = 8'h70;
      apply();
      #3;
      m_key[0] = 8'h71;
      m_op[0]  = 9;
      apply();
      tick();
      serve(1, -1, 0);

      // Asynchronous reset in the middle of WAIT
      set_req(0, 8'h55, 10, $urandom, $urandom);
      tick();
      check("pre_rst_busy", bus.busy_o, 1);
      tick();
      do_reset(0, 8'h55);
      tick();
      serve(2, -1, 0);

      // Tag wrap: random bursts until well past 255 issues
      do_reset(-1, 0);
      tick();
      n_issued = 0;
      while (n_issued < 262) begin
         mask  = $urandom_range(1, (1 << NREQ) - 1);
         npend = 0;
         for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
               m_key[i] = (m_acc[i] + $urandom_range(1, 255)) % 256;
               m_op[i]  = $urandom_range(0, 15);
               m_a[i]   = $urandom;
               m_b[i]   = $urandom;
               npend++;
            end
         end
         apply();
         tick();
         for (int j = 0; j < npend; j++) begin
            if (exp_tag == 255) check("wrap_at_max", bus.alu_key_o, 255);
            serve($urandom_range(0, 2), -1, 0);
            n_issued++;
         end
      end
      check("wrap_idle", bus.busy_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one alu32 (legal 1..16).
REQ-002 SHALL have parameter OPW, default 4, opcode width.
REQ-003 SHALL have parameter KW, default 8, key width.
REQ-004 SHALL have parameter DW, default 32, operand/result width.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort (legal 2..65535).
REQ-006 Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_op_i  in  NREQ*OPW  per-requester opcode, slot i at bits [OPW*(i+1)-1:OPW*i] (same packing for all packed ports).
- req_key_i  in  NREQ*KW  per-requester key; a change of value is a new request.
- req_a_i, req_b_i  in  NREQ*DW  per-requester operands.
- alu_op_o  out  OPW  opcode to ALU.
- alu_key_o  out  KW  issue tag to ALU.
- alu_a_o, alu_b_o  out  DW  operands to ALU.
- alu_key_i  in  KW  tag echoed by ALU when alu_res_i is valid.
- alu_res_i  in  DW  ALU result.
- res_o  out  DW  result to requesters.
- res_key_o  out  KW  requester key the result answers.
- res_valid_o  out  NREQ  one-hot, one-cycle completion strobe.
- err_o  out  NREQ  one-hot, one-cycle timeout strobe.
- busy_o  out  1  high while an operation is in flight.

Function
REQ-007 SHALL keep per-slot acc_key[i] (last accepted key); slot i is pending when req_key_i[i] != acc_key[i].
REQ-008 SHALL implement FSM states IDLE and WAIT only.
REQ-009 IDLE: if any slot pending, SHALL grant the first pending slot scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-010 On grant edge SHALL register alu_op_o/alu_a_o/alu_b_o from the granted slot, acc_key[g] <= req_key_i[g], owner <= g, saved_key <= req_key_i[g], alu_key_o <= seq, set busy_o, enter WAIT; request visible in cycle n gives ALU outputs valid from cycle n+1.
REQ-011 seq SHALL reset to 1, increment after every issue, wrap from 2^KW-1 to 1; 0 is never issued.
REQ-012 WAIT: when alu_key_i == alu_key_o, SHALL on that edge load res_o <= alu_res_i, res_key_o <= saved_key, pulse res_valid_o[owner] for exactly one cycle, set rr_ptr <= (owner+1) mod NREQ, clear busy_o, enter IDLE.
REQ-013 WAIT SHALL count cycles from 0; if count reaches TIMEOUT-1 without match, SHALL pulse err_o[owner] one cycle, set rr_ptr as in REQ-012, clear busy_o, enter IDLE; res_o unchanged.
REQ-014 alu_key_i SHALL be ignored in IDLE; a late echo of an aborted tag SHALL never match since the next issue uses a new seq.
REQ-015 alu_op_o/alu_a_o/alu_b_o/alu_key_o SHALL hold stable throughout WAIT and after return to IDLE until the next grant.
REQ-016 A key change on the in-flight slot SHALL not abort it; it becomes a new pending request served by normal arbitration.
REQ-017 Key changes on a slot before grant SHALL collapse; only the value present on the grant edge is issued.
REQ-018 Minimum issue interval SHALL be ALU echo latency + 1 cycles (completion edge, then grant edge from IDLE).
REQ-019 Match and timeout on the same edge SHALL resolve as match (result delivered, no err_o).

Reset
REQ-020 While rst is low, SHALL asynchronously force: state IDLE, acc_key all 0, seq 1, rr_ptr 0, count 0, owner 0, all alu_* outputs 0, res_o 0, res_key_o 0, res_valid_o 0, err_o 0, busy_o 0.
REQ-021 Reset during WAIT SHALL drop the in-flight operation with no res_valid_o/err_o; requester keys still differing from 0 after release SHALL be pending.

Verification
REQ-022 Single request: slot 2 key 0->0x05, op 3, A 7, B 9; ALU echoes 1 after 3 cycles -> alu_key_o=1 cycle after request, res_valid_o=0b0100 one cycle, res_key_o=0x05.
REQ-023 Fairness: all four slots change key same cycle -> grant order 0,1,2,3; then slots 0 and 3 re-request -> order 0,3 (rr_ptr=0 after slot 3), tags 5,6.
REQ-024 Timeout: TIMEOUT=8, ALU never echoes -> err_o[owner] pulse 8 cycles after issue, busy_o low, later echo of that tag ignored, next issue uses tag+1.
REQ-025 Wrap: KW=8, issue 256 ops -> tags run 1..255 then 1; never 0.
REQ-026 In-flight key change: slot 1 changes key 0x10->0x11 during WAIT -> first result reports 0x10, second op issued afterwards reports 0x11.
REQ-027 Async reset asserted mid-WAIT without clk edge -> all outputs 0 immediately; no strobes after release until a new grant completes.
